// File: rtl/interrupt_receiver.sv
// Receives the unsynchronised 4-bit button interrupt code.
// Synchronises and debounces it, then queues each new non-zero code for the core.
module interrupt_receiver #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] interrupt,
  output logic       irq,
  output logic [3:0] irq_code,
  input  logic       irq_ack,
  output logic       overflow,
  input  logic       clear_overflow
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] CMAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] DEPTH = PW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0]                  r_cand;
  logic [3:0]                  r_acc;
  logic [CW-1:0]               r_cnt;
  logic [3:0]                  r_mem [FIFO_DEPTH];
  logic [PW-1:0]               r_wr;
  logic [PW-1:0]               r_rd;
  logic [3:0]                  r_head;
  logic                        r_ovf;

  logic [3:0]    w_s;
  logic          w_stable;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_drop;
  logic [PW-1:0] w_rd_nx;
  logic [PW-1:0] w_wr_nx;
  logic [3:0]    w_head_nx;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], interrupt};
  end

  // Only the edge that first sees a code held long enough acts on it.
  assign w_stable = (w_s == r_cand) && (r_cnt >= CMAX);
  assign w_push   = w_stable && (r_cand != r_acc) && (r_cand != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (w_s != r_cand) begin
      r_cand <= w_s;
      r_cnt  <= '0;
    end else if (r_cnt < CMAX) begin
      r_cnt  <= r_cnt + CW'(1);
    end else if (r_cand != r_acc) begin
      r_acc  <= r_cand;
    end
  end

  assign w_empty = (r_wr == r_rd);
  assign w_full  = ((r_wr - r_rd) == DEPTH);
  assign w_pop   = irq_ack && !w_empty;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_rd_nx = r_rd + PW'(w_pop);
  assign w_wr_nx = r_wr + PW'(w_wr_en);

  // The new head may be the code being written this very edge.
  always_comb begin
    w_head_nx = r_mem[w_rd_nx[AW-1:0]];
    if (w_rd_nx == w_wr_nx)            w_head_nx = 4'd0;
    else if (w_wr_en && w_rd_nx == r_wr) w_head_nx = r_cand;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= r_cand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_wr   <= w_wr_nx;
      r_rd   <= w_rd_nx;
      r_head <= w_head_nx;
      if (w_drop)              r_ovf <= 1'b1;
      else if (clear_overflow) r_ovf <= 1'b0;
    end
  end

  assign irq      = !w_empty;
  assign irq_code = r_head;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_interrupt_receiver.sv
// Scenario and randomized bench for interrupt_receiver, checked against a
// window-based reference model (last N synchronised samples equal => accept).
module tb_interrupt_receiver;

  localparam int SS = 2;
  localparam int SC = 4;
  localparam int FD = 4;
  localparam int HL = SS + SC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] interrupt = 4'd0;
  logic       irq;
  logic [3:0] irq_code;
  logic       irq_ack = 1'b0;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  int checks = 0;
  int errors = 0;

  interrupt_receiver #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .irq(irq), .irq_code(irq_code),
    .irq_ack(irq_ack), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: input history per edge, plain queue for the FIFO.
  logic [3:0] m_hist [HL];
  logic [3:0] m_q [$];
  logic [3:0] m_acc;
  logic       m_ovf;
  logic       m_pop, m_push, m_drop, m_same;
  logic [3:0] m_v;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < HL; i++) m_hist[i] = 4'd0;
      m_acc = 4'd0;
      m_ovf = 1'b0;
    end else begin
      m_pop = irq_ack && (m_q.size() > 0);
      for (int i = HL - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = interrupt;
      m_v    = m_hist[SS];
      m_same = 1'b1;
      for (int i = SS; i <= SS + SC; i++) if (m_hist[i] != m_v) m_same = 1'b0;
      m_push = 1'b0;
      if (m_same && m_v != m_acc) begin
        m_acc  = m_v;
        m_push = (m_v != 4'd0);
      end
      m_drop = m_push && (m_q.size() == FD) && !m_pop;
      if (m_pop) void'(m_q.pop_front());
      if (m_push && !m_drop) m_q.push_back(m_v);
      if (m_drop) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (irq !== 1'b0 || irq_code !== 4'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: irq=%b code=%h ovf=%b, want 0/0/0", irq, irq_code, overflow);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (irq !== 1'b0 || irq_code !== 4'd0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero cyc%0d: irq=%b code=%h ovf=%b, want 0/0/0", i, irq, irq_code, overflow);
      end
    end
  endtask

  task automatic test_latency_hold();
    interrupt = 4'd3;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checks++;
      if (irq !== (k == 6) || irq_code !== ((k == 6) ? 4'd3 : 4'd0)) begin
        errors++;
        $display("FAIL latency E%0d: irq=%b code=%h, want %b/%h", k, irq, irq_code, (k == 6), (k == 6) ? 4'd3 : 4'd0);
      end
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (irq !== 1'b1 || irq_code !== 4'd3 || m_q.size() != 1) begin
        errors++;
        $display("FAIL hold_once cyc%0d: irq=%b code=%h, want 1/3", i, irq, irq_code);
      end
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0 || irq_code !== 4'd0) begin
      errors++;
      $display("FAIL ack_single: irq=%b code=%h, want 0/0", irq, irq_code);
    end
    interrupt = 4'd0;
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    interrupt = 4'd5;
    repeat (3) tick();
    interrupt = 4'd0;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (irq !== 1'b0 || irq_code !== 4'd0) begin
        errors++;
        $display("FAIL glitch cyc%0d: irq=%b code=%h, want 0/0", i, irq, irq_code);
      end
    end
  endtask

  task automatic test_overflow();
    int seq [9] = '{1, 0, 2, 0, 3, 0, 4, 0, 5};
    foreach (seq[i]) begin
      interrupt = 4'(seq[i]);
      repeat (10) tick();
    end
    interrupt = 4'd0;
    repeat (10) tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b, want 1", overflow);
    end
    for (int e = 1; e <= 4; e++) begin
      checks++;
      if (irq !== 1'b1 || irq_code !== 4'(e)) begin
        errors++;
        $display("FAIL overflow_order #%0d: irq=%b code=%h, want 1/%h", e, irq, irq_code, 4'(e));
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
    end
    checks++;
    if (irq !== 1'b0 || irq_code !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drained: irq=%b code=%h ovf=%b, want 0/0/1", irq, irq_code, overflow);
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int exp [3] = '{3, 4, 6};
    for (int c = 1; c <= 4; c++) begin
      interrupt = 4'(c);
      repeat (10) tick();
      interrupt = 4'd0;
      repeat (10) tick();
    end
    interrupt = 4'd6;
    repeat (6) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (overflow !== 1'b0 || irq !== 1'b1 || irq_code !== 4'd2) begin
      errors++;
      $display("FAIL full_pushpop: ovf=%b irq=%b code=%h, want 0/1/2", overflow, irq, irq_code);
    end
    foreach (exp[i]) begin
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      checks++;
      if (irq_code !== 4'(exp[i])) begin
        errors++;
        $display("FAIL full_order #%0d: code=%h, want %h", i, irq_code, 4'(exp[i]));
      end
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++;
    if (irq !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_drained: irq=%b ovf=%b, want 0/0", irq, overflow);
    end
    interrupt = 4'd0;
    repeat (10) tick();
  endtask

  task automatic test_reset_requeue();
    interrupt = 4'd7;
    repeat (10) tick();
    checks++;
    if (irq !== 1'b1 || irq_code !== 4'd7) begin
      errors++;
      $display("FAIL requeue_pre: irq=%b code=%h, want 1/7", irq, irq_code);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (irq !== 1'b0 || irq_code !== 4'd0) begin
      errors++;
      $display("FAIL requeue_rst: irq=%b code=%h, want 0/0", irq, irq_code);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (irq !== (k == 7) || irq_code !== ((k == 7) ? 4'd7 : 4'd0)) begin
        errors++;
        $display("FAIL requeue R+%0d: irq=%b code=%h, want %b", k, irq, irq_code, (k == 7));
      end
    end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    interrupt = 4'd0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int hold;
    logic [3:0] exp_code;
    for (int seg = 0; seg < 120; seg++) begin
      interrupt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        irq_ack        = ($urandom_range(0, 3) == 0);
        clear_overflow = ($urandom_range(0, 15) == 0);
        tick();
        exp_code = (m_q.size() > 0) ? m_q[0] : 4'd0;
        checks++;
        if (irq !== (m_q.size() > 0) || irq_code !== exp_code || overflow !== m_ovf) begin
          errors++;
          $display("FAIL random seg%0d: irq=%b code=%h ovf=%b, want %b/%h/%b",
                   seg, irq, irq_code, overflow, (m_q.size() > 0), exp_code, m_ovf);
        end
      end
    end
    irq_ack = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency_hold();
    test_glitch();
    test_overflow();
    test_full_push_pop();
    test_reset_requeue();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
